// File: rtl/dac_frame_ctrl.sv
// Dual-channel 12-bit serial DAC frame sequencer: one sample pair per handshake,
// two 16-bit MSB-first frames sharing one generated sclk and one frame-sync line.
module dac_frame_ctrl #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned QUIET_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample_a,
  input  logic [11:0] sample_b,
  input  logic [1:0]  pd_mode,
  input  logic        valid,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_din_a,
  output logic        dac_din_b
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned FRAME_W = 16;

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   sr_a_q, sr_a_d;
  logic [FRAME_W-1:0]   sr_b_q, sr_b_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     half_cnt_q, half_cnt_d;
  logic [CNT_W-1:0]     quiet_cnt_q, quiet_cnt_d;
  logic                 sclk_lo_q, sclk_lo_d;
  logic                 ready_d, busy_d, done_d, sclk_d, sync_n_d, din_a_d, din_b_d;
  logic                 framing_d;

  // State, datapath and output registers; outputs hold the decode of the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_a_q      <= '0;
      sr_b_q      <= '0;
      bit_cnt_q   <= '0;
      half_cnt_q  <= '0;
      quiet_cnt_q <= '0;
      sclk_lo_q   <= 1'b0;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      dac_sclk    <= 1'b1;
      dac_sync_n  <= 1'b1;
      dac_din_a   <= 1'b0;
      dac_din_b   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_a_q      <= sr_a_d;
      sr_b_q      <= sr_b_d;
      bit_cnt_q   <= bit_cnt_d;
      half_cnt_q  <= half_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      sclk_lo_q   <= sclk_lo_d;
      ready       <= ready_d;
      busy        <= busy_d;
      done        <= done_d;
      dac_sclk    <= sclk_d;
      dac_sync_n  <= sync_n_d;
      dac_din_a   <= din_a_d;
      dac_din_b   <= din_b_d;
    end
  end

  // Next-state logic and output decode of the next state.
  always_comb begin
    state_d     = state_q;
    sr_a_d      = sr_a_q;
    sr_b_d      = sr_b_q;
    bit_cnt_d   = bit_cnt_q;
    half_cnt_d  = half_cnt_q;
    quiet_cnt_d = quiet_cnt_q;
    sclk_lo_d   = sclk_lo_q;

    case (state_q)
      IDLE: begin
        if (valid && ready) begin
          state_d    = SETUP;
          sr_a_d     = {2'b00, pd_mode, sample_a};
          sr_b_d     = {2'b00, pd_mode, sample_b};
          bit_cnt_d  = '0;
          half_cnt_d = '0;
          sclk_lo_d  = 1'b0;
        end
      end
      SETUP: begin
        if (half_cnt_q == HALF_LAST) begin
          state_d    = SHIFT;
          half_cnt_d = '0;
          sclk_lo_d  = 1'b1;
        end else begin
          half_cnt_d = half_cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (half_cnt_q == HALF_LAST) begin
          half_cnt_d = '0;
          if (sclk_lo_q) begin
            // sclk rises: advance both lines so din only moves on the rising edge
            sclk_lo_d = 1'b0;
            sr_a_d    = {sr_a_q[FRAME_W-2:0], 1'b0};
            sr_b_d    = {sr_b_q[FRAME_W-2:0], 1'b0};
          end else if (bit_cnt_q == BIT_LAST) begin
            state_d     = QUIET;
            quiet_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            sclk_lo_d = 1'b1;
          end
        end else begin
          half_cnt_d = half_cnt_q + CNT_W'(1);
        end
      end
      QUIET: begin
        if (quiet_cnt_q == QUIET_LAST) begin
          state_d = IDLE;
        end else begin
          quiet_cnt_d = quiet_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    framing_d = (state_d == SETUP) || (state_d == SHIFT);
    ready_d   = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == QUIET) && (state_q != QUIET);
    sclk_d    = !((state_d == SHIFT) && sclk_lo_d);
    sync_n_d  = !framing_d;
    din_a_d   = framing_d && sr_a_d[FRAME_W-1];
    din_b_d   = framing_d && sr_b_d[FRAME_W-1];
  end

endmodule

// File: tb/tb_dac_frame_ctrl.sv
// Self-checking bench for dac_frame_ctrl: default and fastest-divider instances
// checked against frame contents and schedule derived from the frame rules.
module tb_dac_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] sample_a, sample_b;
  logic [1:0]  pd_mode;
  logic        valid0, valid1;
  logic        ready0, busy0, done0, sclk0, sync0, dina0, dinb0;
  logic        ready1, busy1, done1, sclk1, sync1, dina1, dinb1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_frame_ctrl #(.CLK_DIV(2), .QUIET_CYC(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .sample_a(sample_a), .sample_b(sample_b),
    .pd_mode(pd_mode), .valid(valid0), .ready(ready0), .busy(busy0), .done(done0),
    .dac_sclk(sclk0), .dac_sync_n(sync0), .dac_din_a(dina0), .dac_din_b(dinb0)
  );

  dac_frame_ctrl #(.CLK_DIV(1), .QUIET_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample_a(sample_a), .sample_b(sample_b),
    .pd_mode(pd_mode), .valid(valid1), .ready(ready1), .busy(busy1), .done(done1),
    .dac_sclk(sclk1), .dac_sync_n(sync1), .dac_din_a(dina1), .dac_din_b(dinb1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, ready0, 1);
    check({tag, "_busy"},  busy0,  0);
    check({tag, "_done"},  done0,  0);
    check({tag, "_sclk"},  sclk0,  1);
    check({tag, "_sync"},  sync0,  1);
    check({tag, "_din"},   {dina0, dinb0}, 0);
  endtask

  // One frame: handshake, watch the lines until ready returns, compare with the model.
  task automatic frame(input bit sel, input logic [11:0] sa, input logic [11:0] sb,
                       input logic [1:0] pd, input bit keep, input int chg_at,
                       input logic [11:0] chg_val);
    int d, q, n, falls, sync_low, dones, done_k, idle_k;
    logic [15:0] cap_a, cap_b, exp_a, exp_b;
    logic prev_sclk, s_sclk, s_sync, s_done, s_ready, s_busy, s_da, s_db;
    d = sel ? 1 : 2;
    q = sel ? 1 : 4;
    n = 0;
    while (!(sel ? ready1 : ready0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", sel ? ready1 : ready0, 1);
    sample_a = sa;
    sample_b = sb;
    pd_mode  = pd;
    if (sel) valid1 = 1'b1; else valid0 = 1'b1;
    exp_a = {2'b00, pd, sa};
    exp_b = {2'b00, pd, sb};
    cap_a = '0; cap_b = '0;
    falls = 0; sync_low = 0; dones = 0; done_k = 0; idle_k = 0;
    prev_sclk = 1'b1;
    for (int k = 1; k < 400 && idle_k == 0; k++) begin
      @(negedge clk);
      if (!keep) begin
        if (sel) valid1 = 1'b0; else valid0 = 1'b0;
      end
      s_sclk  = sel ? sclk1  : sclk0;
      s_sync  = sel ? sync1  : sync0;
      s_done  = sel ? done1  : done0;
      s_ready = sel ? ready1 : ready0;
      s_busy  = sel ? busy1  : busy0;
      s_da    = sel ? dina1  : dina0;
      s_db    = sel ? dinb1  : dinb0;
      if (prev_sclk && !s_sclk && !s_sync) begin
        cap_a = {cap_a[14:0], s_da};
        cap_b = {cap_b[14:0], s_db};
        falls++;
      end
      prev_sclk = s_sclk;
      if (!s_sync) sync_low++;
      if (s_done) begin
        dones++;
        done_k = k;
      end
      if (k == 1) check("busy_first", {s_busy, s_ready}, 2'b10);
      if (s_ready) idle_k = k;
      if (k == chg_at) sample_a = chg_val;
    end
    check("frame_a", cap_a, exp_a);
    check("frame_b", cap_b, exp_b);
    check("falls", falls, 16);
    check("done_cnt", dones, 1);
    check("done_at", done_k, 33 * d + 1);
    check("sync_low", sync_low, 33 * d);
    check("period", idle_k, 33 * d + q + 1);
  endtask

  initial begin
    int n;
    logic [11:0] ra, rb;
    logic [1:0]  rp;
    rst_n = 1'b0;
    valid0 = 1'b0;
    valid1 = 1'b0;
    sample_a = '0;
    sample_b = '0;
    pd_mode  = '0;
    #12;
    check_idle("reset");
    check("reset_fast", {ready1, busy1, sclk1, sync1, dina1, dinb1}, 6'b101100);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("post_reset");

    frame(0, 12'hABC, 12'h123, 2'b00, 0, 0, 12'h000);
    frame(0, 12'h000, 12'h000, 2'b11, 0, 0, 12'h000);

    // Back-to-back with valid held high and an incrementing source
    for (int i = 0; i < 3; i++)
      frame(0, 12'h100 + 12'(i), 12'h200 + 12'(i), 2'b00, 1, 0, 12'h000);
    frame(0, 12'h555, 12'h0F0, 2'b00, 0, 10, 12'hFFF);
    frame(0, 12'hFFF, 12'h0F0, 2'b00, 0, 0, 12'h000);

    for (int i = 0; i < 4; i++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      rp = 2'($urandom_range(0, 3));
      frame(0, ra, rb, rp, 0, 0, 12'h000);
    end

    frame(1, 12'hABC, 12'h123, 2'b00, 0, 0, 12'h000);
    frame(1, 12'($urandom), 12'h3C5, 2'b01, 0, 0, 12'h000);

    // Asynchronous reset in the middle of SHIFT while sclk is low
    sample_a = 12'h5A5;
    sample_b = 12'hA5A;
    pd_mode  = 2'b00;
    valid0   = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    repeat (18) @(negedge clk);
    n = 0;
    while (sclk0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_shift", {sclk0, sync0}, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_idle("rst_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_frame_ctrl.md
# dac_frame_ctrl

Frame sequencer for the dual-channel 12-bit serial DAC output path of the equalizer. Accepts one sample pair per valid/ready handshake, builds two 16-bit frames (2 don't-care bits, 2 power-down bits, 12 data bits) and shifts them MSB-first on two data lines. The two data lines share one generated serial clock and one frame-sync line. Sits between the filter output stage and the DAC pins, and sets the DAC sample rate through its handshake.

## Interface
- CLK_DIV, 2: system clocks per serial-clock half period; legal range 1..255.
- QUIET_CYC, 4: system clocks sync is held high between frames; legal range 1..255.

- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sample_a  in  12  channel A sample, unsigned.
- sample_b  in  12  channel B sample, unsigned.
- pd_mode  in  2  power-down code placed in frame bits 13:12; 00 selects normal operation.
- valid  in  1  sample pair and pd_mode are presented.
- ready  out  1  high only in IDLE; a transfer occurs when valid and ready are both high.
- busy  out  1  high in SETUP, SHIFT and QUIET.
- done  out  1  one-cycle pulse on the first QUIET cycle.
- dac_sclk  out  1  serial clock; idles high.
- dac_sync_n  out  1  frame sync, active low.
- dac_din_a  out  1  channel A serial data.
- dac_din_b  out  1  channel B serial data.

## Operation
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - state = IDLE; both shift registers = 0; counters = 0.
  - Outputs: ready=1, busy=0, done=0, dac_sclk=1, dac_sync_n=1, dac_din_a=dac_din_b=0.
- Frame format, per channel: {2'b00, pd_mode, sample}, bit 15 first.
- State machine (Moore; all outputs decoded from registered state and registers):
  - IDLE: sync_n=1, sclk=1, ready=1. On valid && ready, load both frames and go to SETUP.
  - SETUP: sync_n=0, sclk=1, din = bit 15. Lasts CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 16 serial-clock periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
    - The DAC samples din on each falling sclk edge.
    - Both shift registers shift left by one at each low-to-high sclk transition, so din changes only while sclk rises.
    - After the 16th high half, go to QUIET.
  - QUIET: sync_n=1, sclk=1, din=0, done=1 on the first cycle only. Lasts QUIET_CYC cycles, then go to IDLE.
- Inputs are sampled only at the handshake. Changes to sample_a, sample_b or pd_mode during busy have no effect on the frame in flight.
- valid held high across frames gives back-to-back frames. ready rises on the first IDLE cycle, so the next handshake can occur that cycle.
- A bit counter (0..15) and a half-period counter (0..CLK_DIV-1) never wrap outside SHIFT; both are cleared on entry to SETUP.

## Timing
- Let T0 be the handshake cycle (last IDLE cycle). The schedule is:
  - SETUP occupies T0+1 .. T0+CLK_DIV.
  - SHIFT occupies T0+CLK_DIV+1 .. T0+33·CLK_DIV.
  - QUIET occupies T0+33·CLK_DIV+1 .. T0+33·CLK_DIV+QUIET_CYC.
  - The next IDLE (ready=1) is T0+33·CLK_DIV+QUIET_CYC+1.
- Defaults (CLK_DIV=2, QUIET_CYC=4):
  - Handshake-to-handshake period is 71 cycles.
  - sclk frequency is clk/4.
  - sync_n is low for 66 cycles.
- The first falling sclk edge occurs when entering SHIFT, so din is stable for CLK_DIV cycles (SETUP) before it.
- The 16th falling edge is followed by CLK_DIV high cycles before sync_n rises.
- sync_n high time between frames ≥ QUIET_CYC+1 cycles (QUIET cycles plus the handshake IDLE cycle).

## Test plan
- Reset: assert rst_n=0 mid-SHIFT with sclk low -> same cycle, outputs are sync_n=1, sclk=1, din=0, ready=1, busy=0. After release with valid=0, they stay idle.
- Single frame, defaults, sample_a=12'hABC, sample_b=12'h123, pd_mode=00, captured on falling sclk edges:
  - din_a bits = 0000_1010_1011_1100; din_b bits = 0000_0001_0010_0011.
  - Exactly 16 falling edges while sync_n=0; done pulses once at T0+67.
- pd_mode=2'b11, sample_a=12'h000 -> captured bits 13:12 = 11 and all other bits 0.
- valid held high with an incrementing sample source -> handshakes every 71 cycles; no frame is skipped or duplicated.
- Change sample_a from 12'h555 to 12'hFFF at T0+10 -> captured frame still carries 555; FFF goes out in the next frame.
- CLK_DIV=1, QUIET_CYC=1 -> sclk = clk/2, frame period 35 cycles, bits identical to the single-frame case.
